// File: rtl/adc_pkg.sv
// Shared definitions for the ADC averaging filter: sample width, FSM states
// and the accumulator width helper.
package adc_pkg;

  localparam int ADC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  // Running sum of 2^depth_log2 full-scale samples fits exactly in this width.
  function automatic int sum_width(input int depth_log2);
    return ADC_W + depth_log2;
  endfunction

endpackage

// File: rtl/adc_avg_ram.sv
// Circular sample buffer for the averaging window: one write port,
// asynchronous read, every entry cleared while rst is low.
module adc_avg_ram
  import adc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [ADC_W-1:0]      wdata,
  output logic [ADC_W-1:0]      rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [ADC_W-1:0] mem_q [DEPTH];
  logic [ADC_W-1:0] mem_d [DEPTH];

  // NOTE: copy the whole array first so every path assigns mem_d and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[addr] = wdata;
  end

  // NOTE: the buffer is deliberately reset; the running sum subtracts the
  // oldest entry during fill and relies on it being exactly zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter over 2^DEPTH_LOG2 ADC samples with a valid/ready
// result port and a sticky overrun flag.
module adc_avg_filter
  import adc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             convst,
  input  logic [ADC_W-1:0] sample_in,
  output logic [ADC_W-1:0] avg_data,
  output logic             avg_valid,
  input  logic             avg_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             warm
);

  localparam int WIN    = 1 << DEPTH_LOG2;
  localparam int SUM_W  = sum_width(DEPTH_LOG2);
  localparam int FILL_W = DEPTH_LOG2 + 1;

  state_e                state_q, state_d;
  logic                  convst_q;
  logic                  primed_q, primed_d;
  logic [ADC_W-1:0]      sample_q, sample_d;
  logic [SUM_W-1:0]      sum_q, sum_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic                  warm_q, warm_d;
  logic [ADC_W-1:0]      avg_data_q, avg_data_d;
  logic                  avg_valid_q, avg_valid_d;
  logic                  overrun_q, overrun_d;

  logic [ADC_W-1:0] oldest;
  logic             convst_rise;
  logic             ovr_set;

  adc_avg_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (state_q == ST_UPDATE),
    .addr  (wr_ptr_q),
    .wdata (sample_q),
    .rdata (oldest)
  );

  assign convst_rise = convst & ~convst_q;

  always_comb begin
    state_d     = state_q;
    primed_d    = primed_q;
    sample_d    = sample_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    warm_d      = warm_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = avg_valid_q;
    ovr_set     = 1'b0;

    if (avg_valid_q && avg_ready) avg_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // The first edge after reset only arms capture: the ADC output holds no conversion yet.
        if (convst_rise) begin
          if (!primed_q) begin
            primed_d = 1'b1;
          end else begin
            sample_d = sample_in;
            state_d  = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        sum_d    = sum_q + SUM_W'(sample_q) - SUM_W'(oldest);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (!warm_q) begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(WIN - 1)) warm_d = 1'b1;
        end
        state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        // A publish that coincides with a handshake replaces accepted data, so it is not an overrun.
        if (warm_q) begin
          avg_data_d  = sum_q[SUM_W-1:DEPTH_LOG2];
          avg_valid_d = 1'b1;
          ovr_set     = avg_valid_q & ~avg_ready;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    overrun_d = (overrun_q & ~ovr_clr) | ovr_set;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      convst_q    <= 1'b0;
      primed_q    <= 1'b0;
      sample_q    <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      warm_q      <= 1'b0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      convst_q    <= convst;
      primed_q    <= primed_d;
      sample_q    <= sample_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      warm_q      <= warm_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign avg_data  = avg_data_q;
  assign avg_valid = avg_valid_q;
  assign overrun   = overrun_q;
  assign warm      = warm_q;

endmodule

// File: tb/tb_adc_avg_filter.sv
// Directed bench for adc_avg_filter (window of 8): expected results are queued
// by the stimulus and compared by a monitor on every accepted handshake.
`timescale 1ns/1ps
module tb_adc_avg_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        convst = 1'b0;
  logic [11:0] sample_in = '0;
  logic [11:0] avg_data;
  logic        avg_valid;
  logic        avg_ready = 1'b0;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic        warm;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q [$];

  // 8 zeros then 8 full-scale samples: window mean steps down, then up through the wrap.
  logic [11:0] ramp_in  [16];
  logic [11:0] ramp_exp [16];

  adc_avg_filter #(.DEPTH_LOG2(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .convst    (convst),
    .sample_in (sample_in),
    .avg_data  (avg_data),
    .avg_valid (avg_valid),
    .avg_ready (avg_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr),
    .warm      (warm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && avg_valid && avg_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", {20'h0, avg_data}, 32'hFFFF_FFFF);
        else check("result", {20'h0, avg_data}, {20'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one convst edge; returns inside the PUBLISH cycle (C+2).
  task automatic start_capture(input logic [11:0] s);
    sample_in = s;
    convst    = 1'b1;
    cycle();
    convst    = 1'b0;
    cycle();
  endtask

  task automatic convst_pulse(input logic [11:0] s);
    start_capture(s);
    repeat (3) cycle();
  endtask

  task automatic ovr_clr_pulse();
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
  endtask

  initial begin
    ramp_exp = '{12'h00E, 12'h00C, 12'h00A, 12'h008, 12'h006, 12'h004, 12'h002, 12'h000,
                 12'h1FF, 12'h3FF, 12'h5FF, 12'h7FF, 12'h9FF, 12'hBFF, 12'hDFF, 12'hFFF};
    for (int i = 0; i < 16; i++) ramp_in[i] = (i < 8) ? 12'h000 : 12'hFFF;

    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    check("rst_avg_data",  {20'h0, avg_data}, 32'h0);
    check("rst_avg_valid", {31'h0, avg_valid}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    check("rst_warm",      {31'h0, warm}, 32'h0);

    // Discarded first edge, then fill gating.
    avg_ready = 1'b1;
    convst_pulse(12'hFFF);
    for (int i = 0; i < 7; i++) convst_pulse(12'h010);
    check("fill7_warm",  {31'h0, warm}, 32'h0);
    check("fill7_valid", {31'h0, avg_valid}, 32'h0);
    exp_q.push_back(12'h010);
    convst_pulse(12'h010);
    check("fill8_warm", {31'h0, warm}, 32'h1);

    // Arithmetic across the pointer wrap.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(ramp_exp[i]);
      convst_pulse(ramp_in[i]);
    end
    check("ramp_valid_cleared", {31'h0, avg_valid}, 32'h0);

    // Latency and backpressure: window is all 0xFFF; each 0x000 removes one.
    avg_ready = 1'b0;
    start_capture(12'h000);
    check("lat_c2_valid", {31'h0, avg_valid}, 32'h0);
    cycle();
    check("lat_c3_valid", {31'h0, avg_valid}, 32'h1);
    check("lat_c3_data",  {20'h0, avg_data}, 32'hDFF);
    cycle();
    convst_pulse(12'h000);
    check("bp_data",    {20'h0, avg_data}, 32'hBFF);
    check("bp_overrun", {31'h0, overrun}, 32'h1);
    ovr_clr_pulse();
    check("bp_ovr_clr", {31'h0, overrun}, 32'h0);

    // Handshake collision with the next publish.
    exp_q.push_back(12'hBFF);
    start_capture(12'h000);
    avg_ready = 1'b1;
    cycle();
    avg_ready = 1'b0;
    check("coll_valid",   {31'h0, avg_valid}, 32'h1);
    check("coll_data",    {20'h0, avg_data}, 32'h9FF);
    check("coll_overrun", {31'h0, overrun}, 32'h0);
    exp_q.push_back(12'h9FF);
    avg_ready = 1'b1;
    repeat (2) cycle();
    avg_ready = 1'b0;
    check("coll_drained", {31'h0, avg_valid}, 32'h0);

    // Overrun set wins over a simultaneous clear.
    convst_pulse(12'h000);
    start_capture(12'h000);
    ovr_clr = 1'b1;
    cycle();
    ovr_clr = 1'b0;
    check("setclr_overrun", {31'h0, overrun}, 32'h1);
    check("setclr_data",    {20'h0, avg_data}, 32'h5FF);
    ovr_clr_pulse();
    exp_q.push_back(12'h5FF);
    avg_ready = 1'b1;
    repeat (2) cycle();
    check("setclr_drained", {31'h0, avg_valid}, 32'h0);

    // Reset asserted in the UPDATE cycle.
    sample_in = 12'h123;
    convst    = 1'b1;
    cycle();
    convst    = 1'b0;
    rst       = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    check("mid_rst_avg_data",  {20'h0, avg_data}, 32'h0);
    check("mid_rst_avg_valid", {31'h0, avg_valid}, 32'h0);
    check("mid_rst_overrun",   {31'h0, overrun}, 32'h0);
    check("mid_rst_warm",      {31'h0, warm}, 32'h0);
    convst_pulse(12'hFFF);
    for (int i = 0; i < 7; i++) convst_pulse(12'h040);
    check("refill7_warm",  {31'h0, warm}, 32'h0);
    check("refill7_valid", {31'h0, avg_valid}, 32'h0);
    exp_q.push_back(12'h040);
    convst_pulse(12'h040);
    check("refill8_warm", {31'h0, warm}, 32'h1);

    repeat (3) cycle();
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
ADC_AVG_FILTER -- requirements
Module: adc_avg_filter

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, log2 of averaging window length (window = 2^DEPTH_LOG2 samples, legal 1..4).
REQ-002 SHALL have clk  input  1  sample-domain clock, same 1 MHz clock that drives controle_adc.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have convst  input  1  convst from controle_adc; a rising edge marks sample_in as valid.
REQ-005 SHALL have sample_in  input  12  parallel ADC result (controle_adc out).
REQ-006 SHALL have avg_data  output  12  windowed mean, unsigned.
REQ-007 SHALL have avg_valid  output  1  avg_data holds an unconsumed result.
REQ-008 SHALL have avg_ready  input  1  consumer accepts avg_data when avg_valid and avg_ready are high on a clk edge.
REQ-009 SHALL have overrun  output  1  sticky: a result was overwritten before acceptance.
REQ-010 SHALL have ovr_clr  input  1  clears overrun.
REQ-011 SHALL have warm  output  1  window fully populated since reset.

Function
REQ-012 SHALL register convst once and detect a rising edge as convst high and the registered value low.
REQ-013 SHALL discard the first rising edge after reset, because controle_adc out holds no conversion yet; every later edge is a capture.
REQ-014 SHALL latch sample_in into a capture register on the capture cycle (cycle C).
REQ-015 SHALL implement FSM IDLE -> UPDATE -> PUBLISH -> IDLE; capture moves IDLE to UPDATE, and UPDATE and PUBLISH each last exactly one cycle.
REQ-016 UPDATE SHALL read the oldest entry at wr_ptr and write the captured sample at wr_ptr.
REQ-016a UPDATE SHALL compute sum <= sum + new - oldest and advance wr_ptr modulo 2^DEPTH_LOG2.
REQ-017 Buffer entries SHALL be zero after reset, so the subtraction during fill is exact.
REQ-018 sum SHALL be 12+DEPTH_LOG2 bits wide and never overflow or underflow.
REQ-019 SHALL count filled entries; warm SHALL rise in the UPDATE cycle that writes the 2^DEPTH_LOG2-th sample and stay high until reset.
REQ-020 PUBLISH SHALL, only if warm, load avg_data <= sum >> DEPTH_LOG2 (truncate, no rounding) and set avg_valid; avg_valid is visible at cycle C+3.
REQ-021 When not warm, PUBLISH SHALL leave avg_data and avg_valid unchanged.
REQ-022 avg_data SHALL hold stable while avg_valid is high and avg_ready is low, except as stated in REQ-024.
REQ-023 avg_valid SHALL clear the cycle after a handshake, unless PUBLISH loads a new result in the same cycle, in which case avg_valid stays high with the new data and overrun is not set.
REQ-024 PUBLISH with avg_valid high and no handshake in that cycle SHALL overwrite avg_data with the newest result and set overrun.
REQ-025 ovr_clr SHALL clear overrun; if ovr_clr and a new overrun occur in the same cycle, overrun SHALL be set.
REQ-026 A convst rising edge while the FSM is not in IDLE SHALL be ignored; this cannot occur at controle_adc rates.
REQ-027 wr_ptr SHALL wrap from 2^DEPTH_LOG2-1 to 0 without a bubble.

Reset
REQ-028 While rst is low on a clk edge, the block SHALL set: FSM=IDLE, avg_data=0, avg_valid=0, overrun=0, warm=0, sum=0, wr_ptr=0, fill count=0, all buffer entries=0, prime flag cleared, convst register=0.
REQ-029 Reset asserted mid-UPDATE or mid-PUBLISH SHALL abort the operation with no partial state retained.

Structure
REQ-030 A shared package adc_pkg SHALL hold ADC_W=12, the FSM state enum, and a function for the sum width.
REQ-031 A sub-module adc_avg_ram SHALL hold the circular buffer (single write port, asynchronous read, synchronous clear on reset); the FSM, sum and handshake logic SHALL live in adc_avg_filter.

Verification
REQ-032 Discard: after reset, drive one convst edge with sample_in=0xFFF, then 8 edges with 0x010 (DEPTH_LOG2=3) -> warm rises on the 8th capture and avg_data=0x010.
REQ-033 Fill gating: after 7 post-discard captures -> avg_valid=0 and warm=0.
REQ-034 Arithmetic and wrap: load 8x0x000, then 8x0xFFF with avg_ready=1 -> results 0x000, 0x1FF, 0x3FF, ... 0xFFF, with no overflow across the pointer wrap.
REQ-035 Backpressure: avg_ready=0 across two publishes -> avg_data is the newest value and overrun=1; ovr_clr pulse -> overrun=0.
REQ-036 Handshake collision: avg_ready=1 in the PUBLISH cycle of the next result -> avg_valid stays 1, new data is shown, and overrun=0.
REQ-037 Reset mid-operation: assert rst in the UPDATE cycle -> all outputs 0, and warm requires 8 fresh captures after the first discarded edge.
